tcs3200_color_reader: RTL and testbench
=======================================

// Module: tcs3200_color_reader
// PURPOSE
//  Colour-sensor front end for the Sensors group: reads a TCS3200-style light-to-frequency
//  sensor. Drives the sensor filter selects S2/S3 and counts output pulses over a fixed
//  gate window for red, green and blue in turn. Publishes one RGB count triple per frame.
//  This is the measuring counterpart of the RGB LED driver: it senses the colour the LED emits.
// PARAMETERS
//  GATE_CYCLES    1_000_000  clk cycles per channel measurement window
//  SETTLE_CYCLES  1000       clk cycles after a filter change before counting starts
//  CNT_W          20         width of each channel count
// PORTS
//  clk         in   1      system clock
//  rst         in   1      synchronous reset, active-high
//  en          in   1      level; high = run frames back-to-back
//  sensor_out  in   1      asynchronous sensor frequency output
//  s2          out  1      filter select S2
//  s3          out  1      filter select S3
//  busy        out  1      high while a frame is in progress
//  valid       out  1      one-cycle pulse; result ports are updated in that cycle
//  red_cnt     out  CNT_W  last complete red count
//  green_cnt   out  CNT_W  last complete green count
//  blue_cnt    out  CNT_W  last complete blue count
// BEHAVIOUR
//  Reset: s2=0, s3=0, busy=0, valid=0, all *_cnt=0; state IDLE, accumulators and timers cleared.
//  Input path: sensor_out passes a 2-FF synchronizer, then a rising-edge detect. One edge = one count.
//  Filter codes {s2,s3}: RED=00, GREEN=11, BLUE=01, CLEAR=10.
//  FSM states:
//   IDLE: s2/s3=00, busy=0. If en=1, go to SETTLE with ch=RED.
//   SETTLE: {s2,s3}=code(ch), busy=1. Lasts exactly SETTLE_CYCLES cycles. Edges are ignored.
//     The accumulator is cleared on exit. Next state is MEASURE.
//   MEASURE: lasts exactly GATE_CYCLES cycles. Each detected edge adds 1 to acc.
//     acc saturates at 2^CNT_W-1 and never wraps. An edge in the last gate cycle is counted.
//     On exit, acc is stored in the shadow register for ch.
//     If ch is the last channel, go to DONE. Otherwise advance ch and go to SETTLE.
//   DONE: one cycle. All *_cnt load from the shadow registers together, and valid=1.
//     If en=1, go to SETTLE with ch=RED (back-to-back frame). Otherwise go to IDLE.
//  Frame length: 1 + 3*(SETTLE_CYCLES+GATE_CYCLES) + 1 cycles, from en sampled high to valid.
//  Dropping en mid-frame does not abort the frame; the block returns to IDLE after DONE.
//  *_cnt hold their values between valid pulses. They never show a partial frame.
//  rst asserted mid-frame: all outputs go to reset values and no valid is produced.
//  Timers are sized with $clog2 of max(GATE_CYCLES, SETTLE_CYCLES).
// CONFIGURATION
//  CLEAR_CHANNEL_EN defined: a fourth channel CLEAR (code 10) is measured after BLUE.
//    Adds port clear_cnt (out, CNT_W), updated with the others at DONE.
//    Frame length becomes 1 + 4*(SETTLE_CYCLES+GATE_CYCLES) + 1.
//  CLEAR_CHANNEL_EN undefined: only the three channels are measured, and clear_cnt does not exist.
// STRUCTURE
//  Shared package/include tcs3200_pkg holds:
//   - filter code localparams (FILT_RED/GREEN/BLUE/CLEAR)
//   - FSM state encodings (IDLE, SETTLE, MEASURE, DONE)
//   - channel index encodings
//  Sub-module sync_edge_detect: 2-FF synchronizer plus rising-edge pulse.
//   Ports: clk, rst, d_async, rise. It is reusable by other Sensors blocks.
//  FSM, timers, accumulator and shadow/result registers stay in the top module.
// TESTING (bench params GATE_CYCLES=100, SETTLE_CYCLES=10, CNT_W=8)
//  1. Assert rst 3 cycles with en=1 -> s2=s3=busy=valid=0 and all counts 0 during reset.
//  2. en=1; sensor period 10 on RED, 5 on GREEN, 20 on BLUE, chosen by observed {s2,s3}
//     -> valid at cycle 332; red=10, green=20, blue=5 (+/-1).
//  3. CNT_W=5, period-2 input for the whole frame -> all counts=31 (saturated, no wrap).
//  4. Pulses only while in SETTLE, none in MEASURE -> all counts=0, valid still asserted.
//  5. Drop en at cycle 50 of the frame -> the frame completes with one valid pulse.
//     Next cycle: busy=0, s2=s3=0. No second frame starts.
//  6. rst in GREEN MEASURE -> no valid; counts stay 0.
//     Rebuild with CLEAR_CHANNEL_EN and code-10 period 4 -> clear_cnt=25 (+/-1), valid at cycle 442.

Source files
------------

// File: rtl/tcs3200_pkg.sv
// tcs3200_pkg: filter codes, FSM states and channel indices shared by the TCS3200 colour reader.
package tcs3200_pkg;
  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_GREEN = 2'b11;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_e;
  typedef enum logic [1:0] {CH_RED, CH_GREEN, CH_BLUE, CH_CLEAR} ch_e;
  function automatic logic [1:0] filt_code(input ch_e c);
    return c == CH_RED ? FILT_RED : c == CH_GREEN ? FILT_GREEN : c == CH_BLUE ? FILT_BLUE : FILT_CLEAR;
  endfunction
endpackage

// File: rtl/tcs3200_color_reader_sync_edge_detect.sv
// sync_edge_detect: 2-FF synchronizer followed by a one-cycle rising-edge pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic rise
);
  logic [2:0] sr;
  always_ff @(posedge clk) begin
    sr <= rst ? 3'b000 : {sr[1:0], d_async};
  end
  assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/tcs3200_color_reader.sv
// tcs3200_color_reader: gated pulse counting of TCS3200 R/G/B per frame; define CLEAR_CHANNEL_EN to add a CLEAR channel.
module tcs3200_color_reader
  import tcs3200_pkg::*;
#(
  parameter int GATE_CYCLES   = 1_000_000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CNT_W         = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sensor_out,
  output logic             s2,
  output logic             s3,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt
`ifdef CLEAR_CHANNEL_EN
  ,
  output logic [CNT_W-1:0] clear_cnt
`endif
);
  localparam int MAX_C = GATE_CYCLES > SETTLE_CYCLES ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW = MAX_C > 1 ? $clog2(MAX_C) : 1;
  localparam logic [TW-1:0] S_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] G_LAST = TW'(GATE_CYCLES - 1);
`ifdef CLEAR_CHANNEL_EN
  localparam ch_e LAST_CH = CH_CLEAR;
`else
  localparam ch_e LAST_CH = CH_BLUE;
`endif
  state_e state, state_nx;
  ch_e ch, ch_nx;
  logic [TW-1:0] tmr;
  logic [CNT_W-1:0] acc, acc_nx;
  logic [CNT_W-1:0] shadow [4];
  logic rise, settle_end, gate_end, timing;
  sync_edge_detect u_sync (
    .clk(clk),
    .rst(rst),
    .d_async(sensor_out),
    .rise(rise)
  );
  assign timing = state == SETTLE || state == MEASURE;
  assign settle_end = state == SETTLE && tmr == S_LAST;
  assign gate_end = state == MEASURE && tmr == G_LAST;
  assign acc_nx = (rise && acc != '1) ? acc + 1'b1 : acc;
  assign {s2, s3} = timing ? filt_code(ch) : FILT_RED;
  assign busy = state != IDLE;
  assign valid = state == DONE;
  always_comb begin
    state_nx = state;
    ch_nx = ch;
    case (state)
      IDLE: begin
        state_nx = en ? SETTLE : IDLE;
        ch_nx = CH_RED;
      end
      SETTLE: state_nx = settle_end ? MEASURE : SETTLE;
      MEASURE: begin
        state_nx = !gate_end ? MEASURE : ch == LAST_CH ? DONE : SETTLE;
        ch_nx = (gate_end && ch != LAST_CH) ? ch_e'(ch + 2'd1) : ch;
      end
      DONE: begin
        state_nx = en ? SETTLE : IDLE;
        ch_nx = CH_RED;
      end
    endcase
  end
  // Results load on the edge into DONE so they are already visible while valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch <= CH_RED;
      tmr <= '0;
      acc <= '0;
      shadow <= '{default: '0};
      red_cnt <= '0;
      green_cnt <= '0;
      blue_cnt <= '0;
`ifdef CLEAR_CHANNEL_EN
      clear_cnt <= '0;
`endif
    end else begin
      state <= state_nx;
      ch <= ch_nx;
      tmr <= (settle_end || gate_end || !timing) ? '0 : tmr + 1'b1;
      acc <= state == MEASURE ? acc_nx : '0;
      if (gate_end) shadow[ch] <= acc_nx;
      if (gate_end && ch == LAST_CH) begin
        red_cnt <= shadow[CH_RED];
        green_cnt <= shadow[CH_GREEN];
`ifdef CLEAR_CHANNEL_EN
        blue_cnt <= shadow[CH_BLUE];
        clear_cnt <= acc_nx;
`else
        blue_cnt <= acc_nx;
`endif
      end
    end
  end
endmodule

// File: tb/tb_tcs3200_color_reader.sv
// tb_tcs3200_color_reader: scoreboard bench; expected counts come from gate length / pulse period.
module tb_tcs3200_color_reader;
  localparam int G = 100, S = 10, W = 8, SW = 5;
`ifdef CLEAR_CHANNEL_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 3;
`endif
  localparam int FRAME_LEN = 1 + NCH * (S + G) + 1;
  logic clk = 0, rst = 1, en = 0, sensor = 0, en_sat = 0, sensor_sat = 0;
  logic s2, s3, busy, valid, s2_sat, s3_sat, busy_sat, valid_sat;
  logic [W-1:0] red_cnt, green_cnt, blue_cnt;
  logic [SW-1:0] red_sat, green_sat, blue_sat;
`ifdef CLEAR_CHANNEL_EN
  logic [W-1:0] clear_cnt;
  logic [SW-1:0] clear_sat;
`endif
  typedef struct {int r; int g; int b; int c; int cyc;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, phase = 0, sat_seen = 0;
  int per [4];
  bit gen_on = 1;

  tcs3200_color_reader #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .sensor_out(sensor), .s2(s2), .s3(s3), .busy(busy), .valid(valid),
    .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt)
`ifdef CLEAR_CHANNEL_EN
    , .clear_cnt(clear_cnt)
`endif
  );
  tcs3200_color_reader #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(SW)) dut_sat (
    .clk(clk), .rst(rst), .en(en_sat), .sensor_out(sensor_sat), .s2(s2_sat), .s3(s3_sat), .busy(busy_sat),
    .valid(valid_sat), .red_cnt(red_sat), .green_cnt(green_sat), .blue_cnt(blue_sat)
`ifdef CLEAR_CHANNEL_EN
    , .clear_cnt(clear_sat)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model(input int p, input int w);
    if (p < 2) return 0;
    return (G / p > (1 << w) - 1) ? (1 << w) - 1 : G / p;
  endfunction

  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (+/-%0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Sensor waveform: square wave whose period depends on the filter code the DUT currently selects.
  initial forever begin
    @(negedge clk);
    phase++;
    if (gen_on) sensor = per[{s2, s3}] < 2 ? 1'b0 : (phase % per[{s2, s3}]) < per[{s2, s3}] / 2;
  end
  initial forever begin
    @(negedge clk);
    sensor_sat = ~sensor_sat;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 expected none at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("valid_cycle", cyc, e.cyc, 0);
        chk("red_cnt", int'(red_cnt), e.r, e.r == 0 ? 0 : 1);
        chk("green_cnt", int'(green_cnt), e.g, e.g == 0 ? 0 : 1);
        chk("blue_cnt", int'(blue_cnt), e.b, e.b == 0 ? 0 : 1);
`ifdef CLEAR_CHANNEL_EN
        chk("clear_cnt", int'(clear_cnt), e.c, e.c == 0 ? 0 : 1);
`endif
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (valid_sat) begin
      sat_seen++;
      chk("sat_red", int'(red_sat), 31, 0);
      chk("sat_green", int'(green_sat), 31, 0);
      chk("sat_blue", int'(blue_sat), 31, 0);
`ifdef CLEAR_CHANNEL_EN
      chk("sat_clear", int'(clear_sat), 31, 0);
`endif
    end
  end

  task automatic set_per(input int pr, input int pg, input int pb, input int pc);
    per[0] = pr;
    per[3] = pg;
    per[1] = pb;
    per[2] = pc;
  endtask

  task automatic push_exp(input int at);
    q.push_back('{model(per[0], W), model(per[3], W), model(per[1], W), NCH == 4 ? model(per[2], W) : 0, at});
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 2 * FRAME_LEN && busy; i++) @(negedge clk);
    if (busy) timeout("wait_idle");
  endtask

  task automatic wait_valid();
    int i;
    for (i = 0; i < 2 * FRAME_LEN && !valid; i++) @(negedge clk);
    if (!valid) timeout("wait_valid");
  endtask

  task automatic one_frame();
    push_exp(cyc + FRAME_LEN - 1);
    en = 1;
    @(negedge clk);
    en = 0;
    wait_idle();
  endtask

  initial begin
    set_per(10, 5, 20, 4);
    en = 1;
    en_sat = 1;
    repeat (3) @(negedge clk);
    chk("rst_s2", int'(s2), 0, 0);
    chk("rst_s3", int'(s3), 0, 0);
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_valid", int'(valid), 0, 0);
    chk("rst_red", int'(red_cnt), 0, 0);
    chk("rst_green", int'(green_cnt), 0, 0);
    chk("rst_blue", int'(blue_cnt), 0, 0);
    rst = 0;
    en = 0;
    @(negedge clk);
    en_sat = 0;
    one_frame();
    // Pulses confined to the early part of each SETTLE window must not be counted.
    gen_on = 0;
    sensor = 0;
    push_exp(0);
    q[q.size() - 1] = '{0, 0, 0, 0, cyc + FRAME_LEN - 1};
    en = 1;
    @(negedge clk);
    en = 0;
    for (int c = 0; c < NCH; c++) begin
      repeat (S - 4) begin
        sensor = ~sensor;
        @(negedge clk);
      end
      sensor = 0;
      repeat (G + 4) @(negedge clk);
    end
    wait_idle();
    gen_on = 1;
    set_per(7, 3, 12, 9);
    push_exp(cyc + FRAME_LEN - 1);
    push_exp(cyc + 2 * (FRAME_LEN - 1));
    en = 1;
    repeat (FRAME_LEN + 50) @(negedge clk);
    en = 0;
    wait_idle();
    set_per(4, 25, 2, 6);
    push_exp(cyc + FRAME_LEN - 1);
    en = 1;
    repeat (50) @(negedge clk);
    en = 0;
    wait_valid();
    @(negedge clk);
    chk("after_done_busy", int'(busy), 0, 0);
    chk("after_done_s2", int'(s2), 0, 0);
    chk("after_done_s3", int'(s3), 0, 0);
    repeat (FRAME_LEN) @(negedge clk);
    chk("no_restart_busy", int'(busy), 0, 0);
    for (int k = 0; k < 6; k++) begin
      set_per($urandom_range(0, 30), $urandom_range(0, 30), $urandom_range(0, 30), $urandom_range(0, 30));
      one_frame();
    end
    en = 1;
    @(negedge clk);
    en = 0;
    repeat (2 * S + G + 30) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("midrst_busy", int'(busy), 0, 0);
    chk("midrst_valid", int'(valid), 0, 0);
    chk("midrst_s2", int'(s2), 0, 0);
    chk("midrst_s3", int'(s3), 0, 0);
    rst = 0;
    repeat (FRAME_LEN) @(negedge clk);
    chk("midrst_red", int'(red_cnt), 0, 0);
    chk("midrst_green", int'(green_cnt), 0, 0);
    chk("midrst_blue", int'(blue_cnt), 0, 0);
    chk("midrst_idle", int'(busy), 0, 0);
    chk("pending_expect", q.size(), 0, 0);
    chk("sat_frames", sat_seen, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
